shift_reg_serial_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4-bit universal shift register and turns it into a handshaked nibble serializer. It accepts 4-bit words on a valid/ready input, drives the register's mode, parallel data, serial-fill and clear inputs, and reads back the register's `q`. It presents one serial bit per cycle on a valid/ready output and holds the register while the consumer stalls.

---
 rtl/shift_reg_serial_ctrl_pkg.sv | 25 ++
 rtl/shift_reg_serial_ctrl.sv | 113 +++++++++++
 tb/tb_shift_reg_serial_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_serial_ctrl_pkg.sv
// Shared constants and types for the nibble serializer that drives a 4-bit universal shift register.
package shift_reg_serial_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // The bit that leaves the register next: the top end when shifting up, the bottom end otherwise.
  function automatic logic pick_bit(input logic [NIBBLE_W-1:0] q, input logic msb_first);
    if (msb_first) begin
      return q[NIBBLE_W-1];
    end else begin
      return q[0];
    end
  endfunction

endpackage

// File: rtl/shift_reg_serial_ctrl.sv
// Handshaked nibble serializer: loads a word into the external universal shift register,
// then shifts it out one bit per accepted ser_ready cycle, holding the register on stalls.
module shift_reg_serial_ctrl
  import shift_reg_serial_ctrl_pkg::*;
#(
  parameter logic FILL_BIT = 1'b0
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_data,
  input  logic                in_msb_first,
  output logic                ser_valid,
  input  logic                ser_ready,
  output logic                ser_bit,
  output logic                ser_last,
  output logic [1:0]          reg_mode,
  output logic [NIBBLE_W-1:0] reg_data,
  output logic                reg_left_in,
  output logic                reg_right_in,
  output logic                reg_clear_n,
  input  logic [NIBBLE_W-1:0] reg_q
);

  state_e     r_state;
  logic       r_dir;
  logic [1:0] r_cnt;

  assign reg_data     = in_data;
  assign reg_left_in  = FILL_BIT;
  assign reg_right_in = FILL_BIT;
  // The register clears asynchronously for as long as clear is held.
  assign reg_clear_n  = ~clear;

  // Sequencer state, bit counter and captured bit order.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= SHIFT;
            r_dir   <= in_msb_first;
            r_cnt   <= 2'd0;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= IDLE;
            end else begin
              r_state <= SHIFT;
            end
          end else begin
            r_state <= SHIFT;
          end
        end
        default: begin
          r_state <= IDLE;
          r_dir   <= 1'b0;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Handshake and register-control outputs; ser_valid never depends on ser_ready.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    ser_bit   = 1'b0;
    reg_mode  = MODE_HOLD;
    if (clear) begin
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      reg_mode  = MODE_HOLD;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            reg_mode = MODE_LOAD;
          end else begin
            reg_mode = MODE_HOLD;
          end
        end
        SHIFT: begin
          ser_valid = 1'b1;
          ser_last  = (r_cnt == 2'd3);
          ser_bit   = pick_bit(reg_q, r_dir);
          if (ser_ready) begin
            reg_mode = r_dir ? MODE_UP : MODE_DOWN;
          end else begin
            reg_mode = MODE_HOLD;
          end
        end
        default: begin
          in_ready = 1'b0;
          reg_mode = MODE_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_serial_ctrl.sv
// Directed bench: serializer driving a behavioural universal shift register, with a FILL_BIT=1 twin.
module tb_shift_reg_serial_ctrl;

  logic       clk;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_msb_first;
  logic       ser_ready;

  logic       in_ready,  ser_valid,  ser_bit,  ser_last,  left_in,  right_in,  clear_n;
  logic [1:0] mode;
  logic [3:0] data, q;
  logic       in_ready2, ser_valid2, ser_bit2, ser_last2, left_in2, right_in2, clear_n2;
  logic [1:0] mode2;
  logic [3:0] data2, q2;

  int errors = 0;
  int checks = 0;

  shift_reg_serial_ctrl #(.FILL_BIT(1'b0)) dut (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_msb_first(in_msb_first), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_bit(ser_bit),
    .ser_last(ser_last), .reg_mode(mode), .reg_data(data), .reg_left_in(left_in),
    .reg_right_in(right_in), .reg_clear_n(clear_n), .reg_q(q)
  );

  shift_reg_serial_ctrl #(.FILL_BIT(1'b1)) dut_fill1 (
    .clk(clk), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_msb_first(in_msb_first), .ser_valid(ser_valid2), .ser_ready(ser_ready), .ser_bit(ser_bit2),
    .ser_last(ser_last2), .reg_mode(mode2), .reg_data(data2), .reg_left_in(left_in2),
    .reg_right_in(right_in2), .reg_clear_n(clear_n2), .reg_q(q2)
  );

  // Behavioural universal shift registers (async active-low clear).
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) q <= 4'b0000;
    else case (mode)
      2'b01:   q <= {q[2:0], right_in};
      2'b10:   q <= {left_in, q[3:1]};
      2'b11:   q <= data;
      default: q <= q;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n2) begin
    if (!clear_n2) q2 <= 4'b0000;
    else case (mode2)
      2'b01:   q2 <= {q2[2:0], right_in2};
      2'b10:   q2 <= {left_in2, q2[3:1]};
      2'b11:   q2 <= data2;
      default: q2 <= q2;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    clear = 1'b1; in_valid = 1'b1; in_data = 4'b1111; in_msb_first = 1'b0; ser_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (clear_n !== 1'b0) begin errors++; $display("FAIL reset_clear_n got=%b exp=0", clear_n); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", mode); end
    end
    clear = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got=%b exp=1", in_ready); end
    checks++; if (ser_valid !== 1'b0 || ser_last !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b%b exp=00", ser_valid, ser_last); end
    checks++; if (mode !== 2'b00) begin errors++; $display("FAIL reset_idle_mode got=%b exp=00", mode); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL reset_q got=%b exp=0000", q); end
    checks++; if (left_in !== 1'b0 || right_in2 !== 1'b1) begin errors++; $display("FAIL fill_ties got=%b%b exp=01", left_in, right_in2); end
  endtask

  task automatic test_msb_first();
    logic [3:0] e;
    e = 4'b1101;
    in_data = 4'b1101; in_msb_first = 1'b1; in_valid = 1'b1; ser_ready = 1'b1;
    #1;
    checks++; if (mode !== 2'b11 || data !== 4'b1101) begin errors++; $display("FAIL msb_load got=%b/%b exp=11/1101", mode, data); end
    tick(); in_valid = 1'b0; in_data = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL msb_valid%0d got=%b%b exp=10", i, ser_valid, in_ready); end
      checks++; if (ser_bit !== e[3-i]) begin errors++; $display("FAIL msb_bit%0d got=%b exp=%b", i, ser_bit, e[3-i]); end
      checks++; if (ser_last !== (i == 3)) begin errors++; $display("FAIL msb_last%0d got=%b exp=%b", i, ser_last, (i == 3)); end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL msb_mode%0d got=%b exp=01", i, mode); end
      tick();
    end
    #1;
    checks++; if (in_ready !== 1'b1 || ser_valid !== 1'b0) begin errors++; $display("FAIL msb_done got=%b%b exp=10", in_ready, ser_valid); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL msb_q_end got=%b exp=0000", q); end
  endtask

  task automatic test_lsb_first();
    logic [3:0] e;
    e = 4'b1101;
    in_data = 4'b1101; in_msb_first = 1'b0; in_valid = 1'b1; ser_ready = 1'b1;
    #1;
    checks++; if (mode !== 2'b11) begin errors++; $display("FAIL lsb_load got=%b exp=11", mode); end
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_bit !== e[i]) begin errors++; $display("FAIL lsb_bit%0d got=%b exp=%b", i, ser_bit, e[i]); end
      checks++; if (mode !== 2'b10) begin errors++; $display("FAIL lsb_mode%0d got=%b exp=10", i, mode); end
      tick();
    end
    #1;
    checks++; if (q !== 4'b0000 || in_ready !== 1'b1) begin errors++; $display("FAIL lsb_done got=%b/%b exp=0000/1", q, in_ready); end
  endtask

  task automatic test_backpressure();
    logic [3:0] e;
    int cycles;
    e = 4'b1010;
    in_data = 4'b1010; in_msb_first = 1'b1; in_valid = 1'b1; ser_ready = 1'b0;
    cycles = 0;
    tick(); cycles++; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mode !== 2'b00 || ser_bit !== 1'b1 || ser_valid !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got=%b/%b/%b exp=00/1/1", i, mode, ser_bit, ser_valid); end
      checks++; if (ser_last !== 1'b0) begin errors++; $display("FAIL bp_stall_last%0d got=%b exp=0", i, ser_last); end
      tick(); cycles++;
    end
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_bit !== e[3-i] || ser_last !== (i == 3)) begin errors++; $display("FAIL bp_bit%0d got=%b%b exp=%b%b", i, ser_bit, ser_last, e[3-i], (i == 3)); end
      tick(); cycles++;
    end
    #1;
    checks++; if (cycles !== 8 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_total got=%0d/%b exp=8/1", cycles, in_ready); end
  endtask

  task automatic test_fill_one();
    in_data = 4'b0000; in_msb_first = 1'b0; in_valid = 1'b1; ser_ready = 1'b1;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_bit2 !== 1'b0 || ser_valid2 !== 1'b1) begin errors++; $display("FAIL fill_bit%0d got=%b%b exp=01", i, ser_bit2, ser_valid2); end
      tick();
    end
    #1;
    checks++; if (q2 !== 4'b1111) begin errors++; $display("FAIL fill_q_end got=%b exp=1111", q2); end
    checks++; if (q !== 4'b0000) begin errors++; $display("FAIL fill0_q_end got=%b exp=0000", q); end
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] e;
    in_data = 4'b0110; in_msb_first = 1'b1; in_valid = 1'b1; ser_ready = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    clear = 1'b1;
    #1;
    checks++; if (clear_n !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_clear got=%b%b%b exp=000", clear_n, ser_valid, in_ready); end
    checks++; if (q !== 4'b0000 || mode !== 2'b00) begin errors++; $display("FAIL mid_clear_q got=%b/%b exp=0000/00", q, mode); end
    tick(); clear = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || ser_valid !== 1'b0 || q !== 4'b0000) begin errors++; $display("FAIL mid_after got=%b%b/%b exp=10/0000", in_ready, ser_valid, q); end
    e = 4'b1001;
    in_data = 4'b1001; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_bit !== e[3-i] || ser_valid !== 1'b1) begin errors++; $display("FAIL mid_next_bit%0d got=%b exp=%b", i, ser_bit, e[3-i]); end
      tick();
    end
  endtask

  task automatic test_ignored_input();
    logic [3:0] e1, e2;
    e1 = 4'b0101; e2 = 4'b1100;
    in_data = 4'b0101; in_msb_first = 1'b1; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_data = 4'b1111 - 4'(i); in_msb_first = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0 || mode !== 2'b01) begin errors++; $display("FAIL ign_ready%0d got=%b/%b exp=0/01", i, in_ready, mode); end
      checks++; if (ser_bit !== e1[3-i]) begin errors++; $display("FAIL ign_bit%0d got=%b exp=%b", i, ser_bit, e1[3-i]); end
      tick();
    end
    in_data = 4'b1100; in_msb_first = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || mode !== 2'b11) begin errors++; $display("FAIL ign_accept got=%b/%b exp=1/11", in_ready, mode); end
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ser_bit !== e2[3-i]) begin errors++; $display("FAIL ign_next_bit%0d got=%b exp=%b", i, ser_bit, e2[3-i]); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_backpressure();
    test_fill_one();
    test_reset_mid_word();
    test_ignored_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
